alu_instr_sequencer: RTL and testbench
======================================

ALU_INSTR_SEQUENCER -- requirements
Module: alu_instr_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, datapath/instruction width.
REQ-002 Parameter SEL_W, default 5, bus-select index width (2**SEL_W bus sources).
REQ-003 Parameter EN_W, default 32, width of multi-hot register-enable vector.
REQ-004 Parameter OP_W, default 5, ALU operation code width.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 clr  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  request to execute one instruction; sampled only in IDLE.
REQ-008 mem_ready  in  1  memory read data valid on MDataIn path.
REQ-009 ir  in  DATA_W  instruction register contents; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-010 bus_sel  out  SEL_W  index of source driving the bus.
REQ-011 bus_sel_vld  out  1  bus_sel meaningful; 0 means bus idle.
REQ-012 en  out  EN_W  multi-hot register load enables (bit i loads register index i).
REQ-013 inc_pc, md_read  out  1 each  PC increment, memory read strobe.
REQ-014 alu_op  out  OP_W  ALU operation, valid in T4 only, else 0.
REQ-015 busy, done, err  out  1 each  in-flight, successful completion pulse, illegal-opcode pulse.

Function
REQ-016 States IDLE, T0, T1, T2, T3, T4, T5, T6; outputs are Moore decode of state plus ir fields.
REQ-017 IDLE: all outputs 0; start=1 -> T0 next edge; busy=1 in every non-IDLE state.
REQ-018 T0: bus_sel=SEL_PC, en bits EN_MAR and EN_PC set, inc_pc=1; -> T1.
REQ-019 T1: md_read=1, en bit EN_MDR, bus idle; stays in T1 while mem_ready=0 (unbounded stall); -> T2 on mem_ready=1.
REQ-020 T2: bus_sel=SEL_MDR, en bit EN_IR; -> T3.
REQ-021 T3: bus_sel=ir.Rb, en bit EN_Y; ir opcode/Ra/Rc latched internally on T3 exit; ir may change afterwards.
REQ-022 T3 exit with illegal opcode (not in package ALU set): err=1 for one cycle in IDLE-return transition, -> IDLE, no register written.
REQ-023 T4: bus_sel=latched Rc, en bit EN_Z, alu_op=latched opcode; -> T5.
REQ-024 T5 normal op: bus_sel=SEL_ZLO, en bit = latched Ra; done=1; -> IDLE.
REQ-025 T5 for MUL/DIV: bus_sel=SEL_ZLO, en bit EN_LO; -> T6. T6: bus_sel=SEL_ZHI, en bit EN_HI, done=1; -> IDLE.
REQ-026 Latency start->done: 6 cycles (7 for MUL/DIV) plus T1 stall cycles.
REQ-027 start while busy is ignored, not queued; start in same cycle as done's IDLE return is not accepted until IDLE.
REQ-028 Register index fields are zero-extended to SEL_W/EN_W; Ra=Rb=Rc permitted.

Reset
REQ-029 clr=1 forces IDLE asynchronously in any state including T1 stall; all outputs 0 and latched fields 0 while clr high.
REQ-030 First start accepted on the first rising edge after clr deasserts.

Structure
REQ-031 Shared package holds state enum, opcode constants (SHR=7, MUL=15, DIV=16, legal ALU set), and index constants SEL_ZHI=18, SEL_ZLO=19, SEL_PC=20, SEL_MDR=21, EN_HI=16, EN_LO=17, EN_PC=20, EN_MDR=21, EN_IR=23, EN_Z=24, EN_MAR=25, EN_Y=27.
REQ-032 One sub-module, alu_instr_decode: combinational ir-to-{legal, is_muldiv, ra, rb, rc, op} decoder; FSM stays in top.

Verification
REQ-033 start, mem_ready=1, ir=0x389A8000 -> T3 bus_sel=3 en[27]; T4 bus_sel=5 alu_op=7 en[24]; T5 bus_sel=19 en[1] done=1; 6 cycles.
REQ-034 Same, mem_ready low 3 cycles in T1 -> md_read held 4 cycles, done at cycle 9, outputs otherwise identical.
REQ-035 ir opcode 15, Ra=2,Rb=4,Rc=6 -> T5 bus_sel=19 en[17]; T6 bus_sel=18 en[16] done=1; en[2] never set.
REQ-036 ir opcode 31 -> err pulse after T3, return to IDLE, no en bit for Ra/Z ever set, done=0.
REQ-037 clr pulsed mid-T4 -> all outputs 0 immediately, IDLE; next start runs full sequence cleanly.
REQ-038 start held high through whole instruction -> exactly one instruction executed, second begins only after IDLE.

Source files
------------

// File: rtl/alu_instr_sequencer_pkg.sv
// rtl/alu_instr_sequencer_pkg.sv - shared states, opcodes and bus/enable indices for the ALU sequencer
package alu_instr_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        T6   = 3'd7
    } state_t;

    // Instruction field positions
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 27;
    localparam int RA_HI   = 26;
    localparam int RA_LO   = 23;
    localparam int RB_HI   = 22;
    localparam int RB_LO   = 19;
    localparam int RC_HI   = 18;
    localparam int RC_LO   = 15;
    localparam int OPC_W   = 5;
    localparam int FIELD_W = 4;

    localparam logic [OPC_W-1:0] OP_SHR = 5'd7;
    localparam logic [OPC_W-1:0] OP_MUL = 5'd15;
    localparam logic [OPC_W-1:0] OP_DIV = 5'd16;

    // ALU set: add..rol (3..11) and mul, div, neg, not (15..18)
    localparam logic [31:0] ALU_LEGAL_MASK = 32'h0007_8FF8;

    localparam int SEL_ZHI = 18;
    localparam int SEL_ZLO = 19;
    localparam int SEL_PC  = 20;
    localparam int SEL_MDR = 21;

    localparam int EN_HI  = 16;
    localparam int EN_LO  = 17;
    localparam int EN_PC  = 20;
    localparam int EN_MDR = 21;
    localparam int EN_IR  = 23;
    localparam int EN_Z   = 24;
    localparam int EN_MAR = 25;
    localparam int EN_Y   = 27;

    function automatic logic is_alu_legal(input logic [OPC_W-1:0] opc);
        return ALU_LEGAL_MASK[opc];
    endfunction

endpackage

// File: rtl/alu_instr_sequencer_decode.sv
// rtl/alu_instr_sequencer_decode.sv - combinational instruction field decoder
module alu_instr_decode
    import alu_instr_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic [DATA_W-1:0]  ir,
    output logic               legal,
    output logic               is_muldiv,
    output logic [FIELD_W-1:0] ra,
    output logic [FIELD_W-1:0] rb,
    output logic [FIELD_W-1:0] rc,
    output logic [OP_W-1:0]    op
);

    logic [OPC_W-1:0] opc;
    logic             unused_ir_low;

    assign opc       = ir[OPC_HI:OPC_LO];
    assign ra        = ir[RA_HI:RA_LO];
    assign rb        = ir[RB_HI:RB_LO];
    assign rc        = ir[RC_HI:RC_LO];
    assign legal     = is_alu_legal(opc);
    assign is_muldiv = (opc == OP_MUL) || (opc == OP_DIV);
    assign op        = OP_W'(opc);

    // Immediate/constant bits below Rc are not used by the ALU sequence
    assign unused_ir_low = ^ir[RC_LO-1:0];

endmodule

// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - fetch/execute control sequencer for register-register ALU instructions
module alu_instr_sequencer
    import alu_instr_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5,
    parameter int EN_W   = 32,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] ir,
    output logic [SEL_W-1:0]  bus_sel,
    output logic              bus_sel_vld,
    output logic [EN_W-1:0]   en,
    output logic              inc_pc,
    output logic              md_read,
    output logic [OP_W-1:0]   alu_op,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t state, state_nxt;

    logic               dec_legal;
    logic               dec_muldiv;
    logic [FIELD_W-1:0] dec_ra;
    logic [FIELD_W-1:0] dec_rb;
    logic [FIELD_W-1:0] dec_rc;
    logic [OP_W-1:0]    dec_op;

    logic [FIELD_W-1:0] ra_q;
    logic [FIELD_W-1:0] rc_q;
    logic [OP_W-1:0]    op_q;
    logic               muldiv_q;
    logic               err_q;

    alu_instr_decode #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_decode (
        .ir        (ir),
        .legal     (dec_legal),
        .is_muldiv (dec_muldiv),
        .ra        (dec_ra),
        .rb        (dec_rb),
        .rc        (dec_rc),
        .op        (dec_op)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fields are captured as T3 is left so ir is free to change during T4..T6
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ra_q     <= '0;
            rc_q     <= '0;
            op_q     <= '0;
            muldiv_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == T3) && !dec_legal;
            if (state == T3) begin
                ra_q     <= dec_ra;
                rc_q     <= dec_rc;
                op_q     <= dec_op;
                muldiv_q <= dec_muldiv;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = T0;
            T0:      state_nxt = T1;
            T1:      if (mem_ready) state_nxt = T2;
            T2:      state_nxt = T3;
            T3:      state_nxt = dec_legal ? T4 : IDLE;
            T4:      state_nxt = T5;
            T5:      state_nxt = muldiv_q ? T6 : IDLE;
            T6:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_sel     = '0;
        bus_sel_vld = 1'b0;
        en          = '0;
        inc_pc      = 1'b0;
        md_read     = 1'b0;
        alu_op      = '0;
        done        = 1'b0;
        busy        = (state != IDLE);
        err         = err_q;
        case (state)
            T0: begin
                bus_sel     = SEL_W'(SEL_PC);
                bus_sel_vld = 1'b1;
                en[EN_MAR]  = 1'b1;
                en[EN_PC]   = 1'b1;
                inc_pc      = 1'b1;
            end
            T1: begin
                md_read    = 1'b1;
                en[EN_MDR] = 1'b1;
            end
            T2: begin
                bus_sel     = SEL_W'(SEL_MDR);
                bus_sel_vld = 1'b1;
                en[EN_IR]   = 1'b1;
            end
            T3: begin
                bus_sel     = SEL_W'(dec_rb);
                bus_sel_vld = 1'b1;
                en[EN_Y]    = 1'b1;
            end
            T4: begin
                bus_sel     = SEL_W'(rc_q);
                bus_sel_vld = 1'b1;
                en[EN_Z]    = 1'b1;
                alu_op      = op_q;
            end
            T5: begin
                bus_sel     = SEL_W'(SEL_ZLO);
                bus_sel_vld = 1'b1;
                if (muldiv_q) begin
                    en[EN_LO] = 1'b1;
                end else begin
                    en   = EN_W'(1) << ra_q;
                    done = 1'b1;
                end
            end
            T6: begin
                bus_sel     = SEL_W'(SEL_ZHI);
                bus_sel_vld = 1'b1;
                en[EN_HI]   = 1'b1;
                done        = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - directed self-checking bench for alu_instr_sequencer
module tb_alu_instr_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir;
    logic [4:0]  bus_sel;
    logic        bus_sel_vld;
    logic [31:0] en;
    logic        inc_pc;
    logic        md_read;
    logic [4:0]  alu_op;
    logic        busy;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc;
    int          md_cnt;
    int          done_cnt;
    int          pc_cnt;
    int          done_cyc;
    logic [31:0] en_acc;

    localparam logic [31:0] FETCH_ENS = (32'd1 << 25) | (32'd1 << 20) | (32'd1 << 21) | (32'd1 << 23);

    alu_instr_sequencer dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .mem_ready   (mem_ready),
        .ir          (ir),
        .bus_sel     (bus_sel),
        .bus_sel_vld (bus_sel_vld),
        .en          (en),
        .inc_pc      (inc_pc),
        .md_read     (md_read),
        .alu_op      (alu_op),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] x);
        n_checks++;
        assert (o === x) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, x);
        end
    endtask

    function automatic logic [63:0] obs();
        return {16'd0, bus_sel_vld, bus_sel, en, alu_op, inc_pc, md_read, busy, done, err};
    endfunction

    // flags = {inc_pc, md_read, busy, done, err}
    function automatic logic [63:0] ev(input logic vld, input logic [4:0] sel, input logic [31:0] e,
                                       input logic [4:0] op, input logic [4:0] fl);
        return {16'd0, vld, sel, e, op, fl};
    endfunction

    task automatic clr_stats();
        cyc = 0; md_cnt = 0; done_cnt = 0; pc_cnt = 0; done_cyc = 0; en_acc = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        en_acc |= en;
        if (md_read) md_cnt++;
        if (inc_pc) pc_cnt++;
        if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = cyc;
        end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; mem_ready = 1'b1; ir = '0;
        clr_stats();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", obs(), 64'd0);

        // Plain SHR: first start taken on the first edge after clr drops
        @(negedge clk);
        clr = 1'b0; start = 1'b1; ir = 32'h389A_8000;
        step(); start = 1'b0;
        chk("shr_T0", obs(), ev(1, 20, (32'd1 << 25) | (32'd1 << 20), 0, 5'b10100));
        step();
        chk("shr_T1", obs(), ev(0, 0, 32'd1 << 21, 0, 5'b01100));
        step();
        chk("shr_T2", obs(), ev(1, 21, 32'd1 << 23, 0, 5'b00100));
        step();
        chk("shr_T3", obs(), ev(1, 3, 32'd1 << 27, 0, 5'b00100));
        step();
        chk("shr_T4", obs(), ev(1, 5, 32'd1 << 24, 7, 5'b00100));
        step();
        chk("shr_T5", obs(), ev(1, 19, 32'd1 << 1, 0, 5'b00110));
        chk("shr_latency", cyc, 6);
        step();
        chk("shr_idle", obs(), 64'd0);

        // Same instruction with three stalled T1 cycles
        clr_stats();
        start = 1'b1; mem_ready = 1'b0;
        step(); start = 1'b0;
        for (int i = 0; i < 30 && done_cnt == 0 && !err; i++) begin
            step();
            if (md_cnt == 4) mem_ready = 1'b1;
        end
        chk("stall_md_read_cycles", md_cnt, 4);
        chk("stall_done_cycle", done_cyc, 9);
        chk("stall_en_union", en_acc, FETCH_ENS | (32'd1 << 27) | (32'd1 << 24) | (32'd1 << 1));
        step();
        chk("stall_idle", obs(), 64'd0);

        // MUL r2 <- r4 * r6, two-cycle writeback, Ra never enabled
        clr_stats();
        mem_ready = 1'b1; start = 1'b1; ir = 32'h7923_0000;
        step(); start = 1'b0;
        step(); step(); step();
        chk("mul_T3", obs(), ev(1, 4, 32'd1 << 27, 0, 5'b00100));
        step();
        chk("mul_T4", obs(), ev(1, 6, 32'd1 << 24, 15, 5'b00100));
        ir = 32'h0000_0000;
        step();
        chk("mul_T5", obs(), ev(1, 19, 32'd1 << 17, 0, 5'b00100));
        step();
        chk("mul_T6", obs(), ev(1, 18, 32'd1 << 16, 0, 5'b00110));
        chk("mul_latency", cyc, 7);
        step();
        chk("mul_idle", obs(), 64'd0);
        chk("mul_no_ra_enable", en_acc[2], 1'b0);

        // DIV r3: seven cycles, HI/LO written, not Ra
        clr_stats();
        start = 1'b1; ir = 32'h8180_0000;
        step(); start = 1'b0;
        for (int i = 0; i < 30 && done_cnt == 0 && !err; i++) step();
        chk("div_latency", done_cyc, 7);
        chk("div_en_union", en_acc, FETCH_ENS | (32'd1 << 27) | (32'd1 << 24) | (32'd1 << 17) | (32'd1 << 16));
        step();

        // Illegal opcode 31: err pulse after T3, nothing written
        clr_stats();
        start = 1'b1; ir = 32'hF800_0000;
        step(); start = 1'b0;
        step(); step(); step();
        chk("ill_T3", obs(), ev(1, 0, 32'd1 << 27, 0, 5'b00100));
        step();
        chk("ill_err_pulse", obs(), ev(0, 0, 0, 0, 5'b00001));
        step();
        chk("ill_err_cleared", obs(), 64'd0);
        chk("ill_no_ra_z", en_acc & 32'h0100_0001, 32'd0);
        chk("ill_no_done", done_cnt, 0);

        // clr asserted mid-T4 clears outputs without waiting for an edge
        clr_stats();
        start = 1'b1; ir = 32'h389A_8000;
        step(); start = 1'b0;
        step(); step(); step(); step();
        chk("clr_pre_T4", obs(), ev(1, 5, 32'd1 << 24, 7, 5'b00100));
        #2 clr = 1'b1;
        #1;
        chk("clr_async_outputs", obs(), 64'd0);
        @(posedge clk);
        #1;
        chk("clr_held_outputs", obs(), 64'd0);
        @(negedge clk);
        clr = 1'b0; start = 1'b1;
        clr_stats();
        step(); start = 1'b0;
        chk("clr_restart_T0", obs(), ev(1, 20, (32'd1 << 25) | (32'd1 << 20), 0, 5'b10100));
        for (int i = 0; i < 30 && done_cnt == 0 && !err; i++) begin
            step();
            if (cyc == 5) ir = 32'hFFFF_FFFF;
        end
        chk("clr_restart_latency", done_cyc, 6);
        chk("clr_restart_en_union", en_acc, FETCH_ENS | (32'd1 << 27) | (32'd1 << 24) | (32'd1 << 1));
        step();

        // start held high: one instruction, next begins only after IDLE
        clr_stats();
        ir = 32'h389A_8000; start = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("hold_single_fetch", pc_cnt, 1);
        chk("hold_single_done", done_cnt, 1);
        chk("hold_idle_gap", obs(), 64'd0);
        step();
        chk("hold_second_T0", obs(), ev(1, 20, (32'd1 << 25) | (32'd1 << 20), 0, 5'b10100));
        start = 1'b0;
        for (int i = 0; i < 30 && busy; i++) step();
        chk("hold_second_done", done_cnt, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
